// File: rtl/mag_frame_ctrl.sv
// Frame sequencer for the Sobel output path. It takes gradient-magnitude beats,
// tracks the pixel position within a fixed frame and zeroes the border pixels.
// It saturates or thresholds each beat to pixel width and tags it with
// sof/eol/eof behind a one-deep output register.
module mag_frame_ctrl #(
  parameter int WIDTH_P   = 8,
  parameter int FRAME_W_P = 640,
  parameter int FRAME_H_P = 480
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 mode_i,
  input  logic [WIDTH_P-1:0]   thresh_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [2*WIDTH_P-1:0] mag_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [WIDTH_P-1:0]   data_o,
  output logic                 sof_o,
  output logic                 eol_o,
  output logic                 eof_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int XW = $clog2(FRAME_W_P);
  localparam int YW = $clog2(FRAME_H_P);
  localparam logic [XW-1:0] X_LAST = XW'(FRAME_W_P - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FRAME_H_P - 1);
  localparam logic [2*WIDTH_P-1:0] MAX_PIX = {{WIDTH_P{1'b0}}, {WIDTH_P{1'b1}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t               r_state;
  logic                 r_mode;
  logic [WIDTH_P-1:0]   r_thresh;
  logic [XW-1:0]        r_x;
  logic [YW-1:0]        r_y;
  logic                 r_last_taken;
  logic                 r_vld_p1;
  logic [WIDTH_P-1:0]   r_data_p1;
  logic                 r_sof_p1;
  logic                 r_eol_p1;
  logic                 r_eof_p1;

  logic                 w_ready;
  logic                 w_take;
  logic                 w_eof_hs;
  logic                 w_x_last;
  logic                 w_y_last;
  logic                 w_border;
  logic [WIDTH_P-1:0]   w_pix;

  // Clamp a magnitude that exceeds the pixel range to all ones.
  function automatic logic [WIDTH_P-1:0] sat_mag(input logic [2*WIDTH_P-1:0] m);
    if (m > MAX_PIX) return {WIDTH_P{1'b1}};
    return m[WIDTH_P-1:0];
  endfunction

  // Binary edge map: full scale at or above the threshold, zero below.
  function automatic logic [WIDTH_P-1:0] thr_pix(input logic [WIDTH_P-1:0] s,
                                                 input logic [WIDTH_P-1:0] t);
    return (s >= t) ? {WIDTH_P{1'b1}} : {WIDTH_P{1'b0}};
  endfunction

  // Accept only while running, before the final pixel, with room in the output register.
  always_comb begin
    w_ready  = (r_state == RUN) && !r_last_taken && (!r_vld_p1 || ready_i);
    w_take   = valid_i && w_ready;
    w_eof_hs = (r_state == RUN) && r_vld_p1 && ready_i && r_eof_p1;
    w_x_last = (r_x == X_LAST);
    w_y_last = (r_y == Y_LAST);
    w_border = (r_x == '0) || w_x_last || (r_y == '0) || w_y_last;
    w_pix    = r_mode ? thr_pix(sat_mag(mag_i), r_thresh) : sat_mag(mag_i);
    if (w_border) w_pix = '0;
  end

  // Frame FSM: config latch, position counters and end-of-input flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_mode       <= 1'b0;
      r_thresh     <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_last_taken <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_state      <= RUN;
            r_mode       <= mode_i;
            r_thresh     <= thresh_i;
            r_x          <= '0;
            r_y          <= '0;
            r_last_taken <= 1'b0;
          end
        end
        RUN: begin
          if (w_take) begin
            if (w_x_last) begin
              r_x <= '0;
              r_y <= r_y + 1'b1;
              if (w_y_last) r_last_taken <= 1'b1;
            end else begin
              r_x <= r_x + 1'b1;
            end
          end
          if (w_eof_hs) begin
            r_state      <= IDLE;
            r_last_taken <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // ---- stage p1: output register, held while downstream stalls ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
      r_sof_p1  <= 1'b0;
      r_eol_p1  <= 1'b0;
      r_eof_p1  <= 1'b0;
    end else if (w_take) begin
      r_vld_p1  <= 1'b1;
      r_data_p1 <= w_pix;
      r_sof_p1  <= (r_x == '0) && (r_y == '0);
      r_eol_p1  <= w_x_last;
      r_eof_p1  <= w_x_last && w_y_last;
    end else if (ready_i) begin
      r_vld_p1  <= 1'b0;
    end
  end

  assign ready_o = w_ready;
  assign valid_o = r_vld_p1;
  assign data_o  = r_data_p1;
  assign sof_o   = r_sof_p1;
  assign eol_o   = r_eol_p1;
  assign eof_o   = r_eof_p1;
  assign busy_o  = (r_state == RUN);
  assign done_o  = w_eof_hs;

endmodule

// File: tb/tb_mag_frame_ctrl.sv
// Directed bench for mag_frame_ctrl on a 4x3 frame: per-beat vector tables for
// whole frames plus hand-written reset, stall and end-of-frame sequences.
module tb_mag_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_i, start_i, mode_i, valid_i, ready_i;
  logic [7:0]  thresh_i;
  logic [15:0] mag_i;
  logic        ready_o, valid_o, sof_o, eol_o, eof_o, busy_o, done_o;
  logic [7:0]  data_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] mag;
    logic [7:0]  data;
    logic        sof;
    logic        eol;
    logic        eof;
  } vec_t;

  vec_t vec [12];
  bit   pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  mag_frame_ctrl #(.WIDTH_P(8), .FRAME_W_P(4), .FRAME_H_P(3)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
    .thresh_i(thresh_i), .valid_i(valid_i), .ready_o(ready_o), .mag_i(mag_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .sof_o(sof_o),
    .eol_o(eol_o), .eof_o(eof_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Border mag everywhere, with two interior beats (5 and 6) overridden.
  task automatic fill(input logic [15:0] bmag, input logic [7:0] bexp,
                      input logic [15:0] m5, input logic [7:0] e5,
                      input logic [15:0] m6, input logic [7:0] e6);
    for (int i = 0; i < 12; i++) begin
      vec[i].mag  = bmag;
      vec[i].data = bexp;
      vec[i].sof  = (i == 0);
      vec[i].eol  = ((i % 4) == 3);
      vec[i].eof  = (i == 11);
    end
    vec[5].mag = m5; vec[5].data = e5;
    vec[6].mag = m6; vec[6].data = e6;
  endtask

  task automatic run_frame(input logic m, input logic [7:0] th, input bit stall, input bit chg);
    int in_idx = 0;
    int out_idx = 0;
    int cyc = 0;
    bit hold = 0;
    logic [7:0] hd;
    logic hs, he, hf;
    start_i = 1'b1; mode_i = m; thresh_i = th; valid_i = 1'b0; ready_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("busy_rise", busy_o, 1);
    if (chg) begin mode_i = ~m; thresh_i = ~th; end
    while (out_idx < 12 && cyc < 200) begin
      valid_i = 1'b1;
      mag_i   = (in_idx < 12) ? vec[in_idx].mag : 16'hFFFF;
      ready_i = stall ? pat[cyc % 4] : 1'b1;
      start_i = chg && (cyc == 3);
      #1;
      if (hold) begin
        chk("hold_valid", valid_o, 1);
        chk("hold_data", data_o, hd);
        chk("hold_tags", {sof_o, eol_o, eof_o}, {hs, he, hf});
      end
      hold = 0;
      if (valid_o && !ready_i) begin
        chk("stall_ready_o", ready_o, 0);
        hold = 1; hd = data_o; hs = sof_o; he = eol_o; hf = eof_o;
      end
      if (in_idx == 12) chk("no_take_after_last", ready_o, 0);
      if (valid_o && ready_i) begin
        chk($sformatf("data_b%0d", out_idx), data_o, vec[out_idx].data);
        chk($sformatf("tags_b%0d", out_idx), {sof_o, eol_o, eof_o},
            {vec[out_idx].sof, vec[out_idx].eol, vec[out_idx].eof});
        chk($sformatf("done_b%0d", out_idx), done_o, (out_idx == 11));
        out_idx++;
      end else begin
        chk("done_idle", done_o, 0);
      end
      if (valid_i && ready_o && in_idx < 12) in_idx++;
      @(posedge clk); #1;
      cyc++;
    end
    start_i = 1'b0;
    chk("frame_complete", out_idx, 12);
    ready_i = 1'b1;
    #1;
    chk("post_busy", busy_o, 0);
    chk("post_valid", valid_o, 0);
    chk("post_ready_o", ready_o, 0);
    chk("post_done", done_o, 0);
    @(posedge clk); #1;
    chk("idle_ready_o", ready_o, 0);
    chk("idle_busy", busy_o, 0);
    valid_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; mode_i = 1'b0; thresh_i = 8'h00;
    valid_i = 1'b0; ready_i = 1'b1; mag_i = 16'h0;
    repeat (2) @(posedge clk); #1;
    chk("rst_outputs", {valid_o, ready_o, sof_o, eol_o, eof_o, busy_o, done_o}, 0);
    chk("rst_data", data_o, 0);
    rst_i = 1'b0;
    @(posedge clk); #1;

    // Frame A: constant 0x10, only interior pixels pass
    fill(16'h0010, 8'h00, 16'h0010, 8'h10, 16'h0010, 8'h10);
    run_frame(1'b0, 8'h00, 1'b0, 1'b0);

    // Frame B: saturation, border mags out of range still zero
    fill(16'hFFFF, 8'h00, 16'h0123, 8'hFF, 16'h00FE, 8'hFE);
    run_frame(1'b0, 8'h00, 1'b0, 1'b0);

    // Frame C: threshold 0x80, config and start wiggled mid-frame
    fill(16'h0200, 8'h00, 16'h0080, 8'hFF, 16'h007F, 8'h00);
    run_frame(1'b1, 8'h80, 1'b0, 1'b1);

    // Frame D: frame A again under 1,0,0,1 backpressure
    fill(16'h0010, 8'h00, 16'h0010, 8'h10, 16'h0010, 8'h10);
    run_frame(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset mid-frame after 6 beats with a pending beat in the output register
    start_i = 1'b1; mode_i = 1'b0; thresh_i = 8'h00; ready_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; valid_i = 1'b1; mag_i = 16'h0010;
    repeat (6) @(posedge clk);
    #1;
    chk("pre_rst_valid", valid_o, 1);
    chk("pre_rst_data", data_o, 8'h10);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    #1;
    chk("midrst_outputs", {valid_o, ready_o, sof_o, eol_o, eof_o, busy_o, done_o}, 0);
    chk("midrst_data", data_o, 0);
    @(posedge clk); #1;
    chk("midrst_idle_ready_o", ready_o, 0);
    chk("midrst_no_done", done_o, 0);
    valid_i = 1'b0;
    run_frame(1'b0, 8'h00, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
